// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the write-back select stage.
//   wb_sel_e   : write-back source select (ALU, MEM, PC+4, IMM)
//   wb_state_e : stage state machine encoding
//   F3_*       : RISC-V load funct3 encodings
// -----------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage : wb_pkg

// File: rtl/wb_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Purely combinational load aligner: selects the addressed byte / halfword /
// word from the raw memory word and sign- or zero-extends it to XLEN.
// Ports:
//   funct3    in  3       load type (F3_* in wb_pkg)
//   addr_lo   in  LANE_W  byte lane of the load address
//   mem_rdata in  XLEN    raw memory word
//   load_data out XLEN    aligned and extended value
// Unknown funct3 codes (and LWU/LD on a 32-bit core) pass mem_rdata through.
// -----------------------------------------------------------------------------
module wb_load_align
  import wb_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] addr_lo,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   load_data
);

  logic [LANE_W-1:0] off;
  logic [XLEN-1:0]   shifted;

  // Natural alignment: the lane bits below the access size are ignored.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    off = addr_lo;
    unique case (funct3)
      F3_LH, F3_LHU: off = addr_lo & ~LANE_W'(1);
      F3_LW, F3_LWU: off = addr_lo & ~LANE_W'(3);
      F3_LD:         off = '0;
      default:       off = addr_lo;
    endcase
  end

  assign shifted = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    unique case (funct3)
      F3_LB:  load_data = XLEN'($signed(shifted[7:0]));
      F3_LBU: load_data = XLEN'(shifted[7:0]);
      F3_LH:  load_data = XLEN'($signed(shifted[15:0]));
      F3_LHU: load_data = XLEN'(shifted[15:0]);
      F3_LW:  load_data = XLEN'($signed(shifted[31:0]));
      F3_LWU: begin
        if (XLEN == 64) load_data = XLEN'(shifted[31:0]);
      end
      F3_LD: begin
        if (XLEN == 64) load_data = shifted;
      end
      default: load_data = mem_rdata;
    endcase
  end

endmodule : wb_load_align

// File: rtl/wb_select_stage.sv
// -----------------------------------------------------------------------------
// wb_select_stage
// Registered write-back stage between MEM and the register file. Selects the
// write-back value (ALU, load data, PC+4, immediate), waits for late load data
// with a timeout, and issues one wb_valid pulse per accepted instruction.
//
// Build option: WB_LOAD_EXT_EN
//   defined   : load data is aligned and extended by wb_load_align
//   undefined : load data is mem_rdata unchanged; funct3/addr_lo are ignored
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   instruction handshake (ready only in IDLE)
//   wb_sel, reg_write, rd instruction control
//   funct3, addr_lo       load type and byte lane
//   alu_result, pc, imm   source operands
//   mem_rvalid, mem_rdata load response
//   wb_valid, wb_we, wb_rd, wb_data, wb_err   registered write-back outputs
// -----------------------------------------------------------------------------
module wb_select_stage
  import wb_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int MEM_TIMEOUT = 16,
  localparam int LANE_W      = $clog2(XLEN / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_sel,
  input  logic              reg_write,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] addr_lo,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              enter_wait;

  logic              wb_valid_d, wb_we_d, wb_err_d;
  logic [4:0]        wb_rd_d;
  logic [XLEN-1:0]   wb_data_d;

  wb_sel_e           sel;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   sel_value;

  assign sel = wb_sel_e'(wb_sel);

  // Held low while reset is asserted so nothing is offered into a stage that
  // is being cleared.
  assign in_ready = rst_n && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // Load data path
  // ---------------------------------------------------------------------------
`ifdef WB_LOAD_EXT_EN
  logic [2:0]        f3_q;
  logic [LANE_W-1:0] lane_q;
  logic [2:0]        align_f3;
  logic [LANE_W-1:0] align_lane;

  // In IDLE the load is being accepted right now; in WAIT_MEM use the copy
  // taken when the wait began.
  assign align_f3   = (state_q == IDLE) ? funct3  : f3_q;
  assign align_lane = (state_q == IDLE) ? addr_lo : lane_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q   <= '0;
      lane_q <= '0;
    end else if (enter_wait) begin
      f3_q   <= funct3;
      lane_q <= addr_lo;
    end
  end

  wb_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .funct3    (align_f3),
    .addr_lo   (align_lane),
    .mem_rdata (mem_rdata),
    .load_data (load_data)
  );
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{funct3, addr_lo};
  assign load_data        = mem_rdata;
`endif

  // ---------------------------------------------------------------------------
  // Source select (PC+4 wraps modulo 2^XLEN by construction)
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_value = alu_result;
    unique case (sel)
      WB_ALU: sel_value = alu_result;
      WB_MEM: sel_value = load_data;
      WB_PC4: sel_value = pc + XLEN'(4);
      WB_IMM: sel_value = imm;
      default: sel_value = alu_result;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    enter_wait = 1'b0;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_err_d   = 1'b0;
    wb_rd_d    = wb_rd;
    wb_data_d  = wb_data;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (sel != WB_MEM || mem_rvalid) begin
            wb_valid_d = 1'b1;
            wb_we_d    = reg_write && (rd != 5'd0);
            wb_rd_d    = rd;
            wb_data_d  = sel_value;
          end else begin
            enter_wait = 1'b1;
            rd_d       = rd;
            rw_d       = reg_write;
            cnt_d      = '0;
            state_d    = WAIT_MEM;
          end
        end
      end

      WAIT_MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data is checked first so a response on the final wait cycle wins
        // over the timeout.
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = rw_q && (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
          state_d    = IDLE;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // MEM_TIMEOUT wait cycles have passed with no response.
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_err   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      wb_valid <= wb_valid_d;
      wb_we    <= wb_we_d;
      wb_err   <= wb_err_d;
      wb_rd    <= wb_rd_d;
      wb_data  <= wb_data_d;
    end
  end

endmodule : wb_select_stage

// File: tb/tb_wb_select_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_select_stage
// Directed, table-driven bench for wb_select_stage (XLEN=32, MEM_TIMEOUT=16).
// Expected load values depend on whether WB_LOAD_EXT_EN is defined.
// -----------------------------------------------------------------------------
module tb_wb_select_stage;

  localparam int XLEN = 32;
  localparam int TO   = 16;

`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      wb_sel;
  logic            reg_write;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [1:0]      addr_lo;
  logic [XLEN-1:0] alu_result, pc, imm;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            wb_valid, wb_we, wb_err;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  always #5 clk = ~clk;

  wb_select_stage #(.XLEN(XLEN), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .reg_write(reg_write), .rd(rd), .funct3(funct3),
    .addr_lo(addr_lo), .alu_result(alu_result), .pc(pc), .imm(imm),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    wb_sel     = 2'd0;
    reg_write  = 1'b0;
    rd         = '0;
    funct3     = '0;
    addr_lo    = '0;
    alu_result = '0;
    pc         = '0;
    imm        = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic offer_load(input logic [2:0] f3, input logic [1:0] lane, input logic [4:0] r);
    in_valid   = 1'b1;
    wb_sel     = 2'd1;
    reg_write  = 1'b1;
    rd         = r;
    funct3     = f3;
    addr_lo    = lane;
    mem_rvalid = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"alu",       2'd0, 1, 5'd5,  3'b000, 2'd0, 32'd15, 0, 0, 32'hAAAA5555, 1, 32'd15, 1};
    vecs[1]  = '{"imm",       2'd3, 1, 5'd31, 3'b000, 2'd0, 0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1};
    vecs[2]  = '{"pc4_rd0",   2'd2, 1, 5'd0,  3'b000, 2'd0, 0, 32'h100, 0, 0, 0, 32'h104, 0};
    vecs[3]  = '{"pc4_wrap",  2'd2, 1, 5'd3,  3'b000, 2'd0, 0, 32'hFFFFFFFC, 0, 0, 0, 32'h0, 1};
    vecs[4]  = '{"alu_norw",  2'd0, 0, 5'd7,  3'b000, 2'd0, 32'h12345678, 0, 0, 0, 0, 32'h12345678, 0};
    vecs[5]  = '{"lb_sext",   2'd1, 1, 5'd9,  3'b000, 2'd1, 32'h11111111, 0, 0, 32'h000080FF, 1,
                 EXT ? 32'hFFFFFF80 : 32'h000080FF, 1};
    vecs[6]  = '{"lbu",       2'd1, 1, 5'd9,  3'b100, 2'd1, 0, 0, 0, 32'h000080FF, 1,
                 EXT ? 32'h00000080 : 32'h000080FF, 1};
    vecs[7]  = '{"lh_lane3",  2'd1, 1, 5'd10, 3'b001, 2'd3, 0, 0, 0, 32'h80011234, 1,
                 EXT ? 32'hFFFF8001 : 32'h80011234, 1};
    vecs[8]  = '{"lhu_lane0", 2'd1, 1, 5'd11, 3'b101, 2'd0, 0, 0, 0, 32'h8001F234, 1,
                 EXT ? 32'h0000F234 : 32'h8001F234, 1};
    vecs[9]  = '{"lw_lane2",  2'd1, 1, 5'd12, 3'b010, 2'd2, 0, 0, 0, 32'h87654321, 1, 32'h87654321, 1};
    vecs[10] = '{"lb_lane3",  2'd1, 1, 5'd13, 3'b000, 2'd3, 0, 0, 0, 32'h7F000000, 1,
                 EXT ? 32'h0000007F : 32'h7F000000, 1};
    vecs[11] = '{"f3_other",  2'd1, 1, 5'd14, 3'b111, 2'd1, 0, 0, 0, 32'hCAFEBABE, 1, 32'hCAFEBABE, 1};
    vecs[12] = '{"lb_rd0",    2'd1, 1, 5'd0,  3'b100, 2'd2, 0, 0, 0, 32'h00420000, 1,
                 EXT ? 32'h00000042 : 32'h00420000, 0};

    // ---------------- reset ----------------
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {wb_valid, wb_we, wb_err, wb_rd, wb_data}, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", in_ready, 1);

    // ---------------- idle rvalid ignored ----------------
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    check("idle_rvalid_ignored", {wb_valid, wb_we, wb_data}, 0);
    mem_rvalid = 1'b0;

    // ---------------- back-to-back table ----------------
    foreach (vecs[i]) begin
      in_valid   = 1'b1;
      wb_sel     = vecs[i].sel;
      reg_write  = vecs[i].rw;
      rd         = vecs[i].rd;
      funct3     = vecs[i].f3;
      addr_lo    = vecs[i].lane;
      alu_result = vecs[i].alu;
      pc         = vecs[i].pc;
      imm        = vecs[i].imm;
      mem_rdata  = vecs[i].rdata;
      mem_rvalid = vecs[i].rvalid;
      tick();
      check({vecs[i].name, "_valid"}, {wb_valid, wb_err, in_ready}, 3'b101);
      check({vecs[i].name, "_data"}, wb_data, vecs[i].exp_data);
      check({vecs[i].name, "_we_rd"}, {wb_we, wb_rd}, {vecs[i].exp_we, vecs[i].rd});
    end
    idle_inputs();
    tick();
    check("pulse_one_cycle", wb_valid, 0);

    // ---------------- wait path: LHU lane 2, data 3 cycles later ----------------
    offer_load(3'b101, 2'd2, 5'd6);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("wait_ready_low", {in_ready, wb_valid}, 0);
      if (i == 2) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBEEF1234;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    check("wait_valid", {wb_valid, wb_err, wb_we, in_ready}, 4'b1011);
    check("wait_data", wb_data, EXT ? 32'h0000BEEF : 32'hBEEF1234);
    check("wait_rd", wb_rd, 6);

    // ---------------- timeout ----------------
    offer_load(3'b010, 2'd0, 5'd8);
    tick();
    idle_inputs();
    for (int i = 0; i < TO; i++) begin
      check("to_waiting", {in_ready, wb_valid}, 0);
      tick();
    end
    check("to_flags", {wb_valid, wb_err, wb_we}, 3'b110);
    check("to_data", wb_data, 0);
    check("to_ready", in_ready, 1);
    tick();
    check("to_pulse_end", {wb_valid, wb_err}, 0);

    // ---------------- data on the final wait cycle beats timeout ----------------
    offer_load(3'b010, 2'd0, 5'd17);
    tick();
    idle_inputs();
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    check("race_flags", {wb_valid, wb_err, wb_we}, 3'b101);
    check("race_data", wb_data, 32'h0BADF00D);

    // ---------------- reset during WAIT_MEM ----------------
    offer_load(3'b000, 2'd0, 5'd4);
    tick();
    idle_inputs();
    tick();
    rst_n = 1'b0;
    tick();
    check("wrst_in_ready", in_ready, 0);
    check("wrst_outputs", {wb_valid, wb_we, wb_err, wb_rd, wb_data}, 0);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    check("wrst_no_write", {wb_valid, wb_we, wb_err, wb_rd, wb_data}, 0);
    check("wrst_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_wb_select_stage

// File: doc/wb_select_stage.md
# wb_select_stage

Registered write-back stage for the 32/64-bit RISC-V core and the parametrised successor to the combinational mem_to_reg mux. It selects the write-back value from four sources: ALU result, load data, PC+4, or immediate. For loads it aligns and sign/zero-extends the data and waits for a variable-latency memory response, with a timeout. It sits between the MEM stage and the register file and issues a one-cycle write strobe per accepted instruction.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- MEM_TIMEOUT, 16, maximum number of cycles to wait for mem_rvalid before aborting.
- LANE_W, $clog2(XLEN/8), derived width of addr_lo; not overridable.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the stage can accept an instruction.
- wb_sel  in  2  source select: 0 ALU, 1 MEM, 2 PC+4, 3 IMM.
- reg_write  in  1  the instruction writes rd.
- rd  in  5  destination register.
- funct3  in  3  load type.
- addr_lo  in  LANE_W  low bits of the load address.
- alu_result, pc, imm  in  XLEN each  source operands.
- mem_rvalid  in  1  load data is valid this cycle.
- mem_rdata  in  XLEN  raw load word.
- wb_valid  out  1  one-cycle write-back pulse.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  destination register for the write.
- wb_data  out  XLEN  write-back value.
- wb_err  out  1  load timed out (pulses together with wb_valid).

## Operation
- State machine states: IDLE, WAIT_MEM.
- in_ready is 1 only in IDLE. An instruction is accepted when in_valid and in_ready are both 1.
- Non-MEM source, or MEM source with mem_rvalid high in the accept cycle:
  - Capture the selected value (PC+4 = pc + 4, modulo 2^XLEN).
  - Pulse wb_valid on the next cycle.
  - Stay in IDLE.
- MEM source without mem_rvalid in the accept cycle:
  - Latch rd, reg_write, funct3 and addr_lo.
  - Clear the timeout counter and enter WAIT_MEM.
- In WAIT_MEM:
  - The counter increments every cycle.
  - When mem_rvalid is seen, extract the data, pulse wb_valid on the next cycle and return to IDLE.
  - If the counter reaches MEM_TIMEOUT without mem_rvalid, pulse wb_valid with wb_we=0, wb_err=1 and wb_data=0 on the next cycle, then return to IDLE.
- If mem_rvalid and the timeout coincide, the data wins and no error is raised.
- wb_we = reg_write AND (rd != 0) AND NOT timeout.
- mem_rvalid is ignored in IDLE when no MEM-source instruction is being accepted.
- Load extraction by funct3, using the byte lane given by addr_lo:
  - 000 LB, 100 LBU: byte at lane addr_lo.
  - 001 LH, 101 LHU: halfword at addr_lo with bit 0 ignored.
  - 010 LW: sign-extended to XLEN; when XLEN=32 this is the whole word.
  - 110 LWU, 011 LD: valid only when XLEN=64.
  - Unsigned variants zero-extend, signed variants sign-extend.
  - Any other funct3 passes mem_rdata through unchanged.
- There is no back-pressure from the register file.

## Timing
- Latency from accept to wb_valid is 1 cycle. For a waiting load, wb_valid follows the mem_rvalid cycle by 1.
- Throughput is one instruction per cycle for non-waiting traffic.
- On reset, all outputs are 0 (wb_valid, wb_we, wb_rd, wb_data, wb_err), in_ready is 0 during the reset cycle, state goes to IDLE and the counter to 0. A reset during WAIT_MEM discards the pending load and produces no write.
- in_ready becomes 1 on the first cycle after reset is released.

## Configuration
- WB_LOAD_EXT_EN defined: load alignment and extension are performed as described in Operation.
- WB_LOAD_EXT_EN undefined: MEM-source data is mem_rdata unchanged, funct3 and addr_lo are ignored, and the alignment logic is not instantiated.

## Structure
- Shared package wb_pkg contains:
  - the wb_sel_e enum (WB_ALU, WB_MEM, WB_PC4, WB_IMM);
  - the wb_state_e enum;
  - the load funct3 constants (F3_LB through F3_LWU).
- One sub-module, wb_load_align: purely combinational, takes (funct3, addr_lo, mem_rdata) and produces extended data. It is instantiated only under WB_LOAD_EXT_EN.

## Test plan
- ALU path: wb_sel=0, alu_result=15, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=15, wb_we=1, wb_rd=5.
- LB with sign extension: mem_rdata=0x000080FF, addr_lo=1, funct3=000, mem_rvalid in the accept cycle -> wb_data=0xFFFFFF80. The same data with LBU (funct3=100) -> 0x00000080.
- Wait path: LHU at addr_lo=2, mem_rdata=0xBEEF1234, mem_rvalid arrives 3 cycles after accept -> in_ready=0 for 3 cycles, wb_data=0x0000BEEF on the cycle after mem_rvalid.
- Timeout: MEM load with no mem_rvalid for 16 cycles -> wb_valid=1, wb_err=1, wb_we=0, then in_ready=1.
- rd=0 with reg_write=1 on the PC4 path, pc=0x100 -> wb_data=0x104, wb_we=0.
- Reset asserted in WAIT_MEM, then mem_rvalid -> no wb_valid and all outputs 0.
